// File: rtl/sevenseg_scan_driver.sv
// Four-digit common-anode seven-segment scan driver for the egg timer display.
// Adds the colon, leading-zero blanking of the minute tens and a whole-display blink.
module sevenseg_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] second_ones,
  input  logic [3:0] second_tens,
  input  logic [3:0] minute_ones,
  input  logic [3:0] minute_tens,
  input  logic       blank_lz,
  input  logic       blink_en,
  output logic [3:0] anode,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] SCAN_LAST  = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } phase_t;

  logic [RW-1:0] scan_cnt_r;
  logic [1:0]    index_r;
  logic [BW-1:0] blink_cnt_r;
  phase_t        phase_r;

  logic [3:0] digit_s;
  logic [3:0] anode_s;
  logic [6:0] seg_s;
  logic       dp_s;

  // Active-low gfedcba pattern; anything outside 0-9 renders as a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = 7'b0111111;
    endcase
    return pattern;
  endfunction

  // Digit refresh counter and scan index.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_r <= '0;
      index_r    <= 2'd0;
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r <= '0;
      index_r    <= index_r + 2'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + RW'(1);
      index_r    <= index_r;
    end
  end

  // Blink half-period counter; held idle in the ON phase while blinking is disabled.
  always_ff @(posedge clk) begin
    if (reset || !blink_en) begin
      blink_cnt_r <= '0;
      phase_r     <= PHASE_ON;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r <= '0;
      phase_r     <= (phase_r == PHASE_ON) ? PHASE_OFF : PHASE_ON;
    end else begin
      blink_cnt_r <= blink_cnt_r + BW'(1);
      phase_r     <= phase_r;
    end
  end

  // Pick the BCD digit for the current scan slot.
  always_comb begin
    digit_s = 4'd0;
    case (index_r)
      2'd0:    digit_s = second_ones;
      2'd1:    digit_s = second_tens;
      2'd2:    digit_s = minute_ones;
      2'd3:    digit_s = minute_tens;
      default: digit_s = 4'd0;
    endcase
  end

  // Next display state; blink gating uses blink_en directly so dropping it reappears in one cycle.
  always_comb begin
    anode_s = 4'b1111;
    seg_s   = 7'b1111111;
    dp_s    = 1'b1;
    if (blink_en && (phase_r == PHASE_OFF)) begin
      anode_s = 4'b1111;
      seg_s   = 7'b1111111;
      dp_s    = 1'b1;
    end else if (blank_lz && (minute_tens == 4'd0) && (index_r == 2'd3)) begin
      anode_s = 4'b1111;
      seg_s   = 7'b1111111;
      dp_s    = 1'b1;
    end else begin
      case (index_r)
        2'd0:    anode_s = 4'b1110;
        2'd1:    anode_s = 4'b1101;
        2'd2:    anode_s = 4'b1011;
        2'd3:    anode_s = 4'b0111;
        default: anode_s = 4'b1111;
      endcase
      seg_s = bcd_to_seg(digit_s);
      dp_s  = (index_r == 2'd2) ? 1'b0 : 1'b1;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      anode <= 4'b1111;
      seg   <= 7'b1111111;
      dp    <= 1'b1;
    end else begin
      anode <= anode_s;
      seg   <= seg_s;
      dp    <= dp_s;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench for sevenseg_scan_driver: a cycle model pushes expected outputs,
// which are popped and compared just after each rising edge.
module tb_sevenseg_scan_driver;

  localparam int R = 4;
  localparam int B = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] second_ones, second_tens, minute_ones, minute_tens;
  logic       blank_lz, blink_en;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       dp;

  int n_vec  = 0;
  int n_miss = 0;

  logic [11:0] exp_q[$];

  // model state
  int  m_cnt  = 0;
  int  m_idx  = 0;
  int  m_bcnt = 0;
  bit  m_off  = 1'b0;

  logic [6:0] seg_tab [16];

  sevenseg_scan_driver #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .reset(reset),
    .second_ones(second_ones), .second_tens(second_tens),
    .minute_ones(minute_ones), .minute_tens(minute_tens),
    .blank_lz(blank_lz), .blink_en(blink_en),
    .anode(anode), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: predict registered outputs from pre-edge state, advance model, then compare.
  task automatic tick(input string tag);
    logic [3:0]  ea;
    logic [6:0]  es;
    logic        ed;
    logic [3:0]  dig;
    logic [11:0] e;
    @(posedge clk);
    dig = (m_idx == 0) ? second_ones : (m_idx == 1) ? second_tens :
          (m_idx == 2) ? minute_ones : minute_tens;
    if (reset || (blink_en && m_off) || (blank_lz && minute_tens == 4'd0 && m_idx == 3)) begin
      ea = 4'b1111; es = 7'b1111111; ed = 1'b1;
    end else begin
      ea = 4'b1111;
      ea[m_idx] = 1'b0;
      es = seg_tab[dig];
      ed = (m_idx == 2) ? 1'b0 : 1'b1;
    end
    exp_q.push_back({ea, es, ed});
    if (reset) begin
      m_cnt = 0; m_idx = 0; m_bcnt = 0; m_off = 1'b0;
    end else begin
      if (m_cnt == R - 1) begin m_cnt = 0; m_idx = (m_idx + 1) % 4; end
      else m_cnt++;
      if (!blink_en) begin m_bcnt = 0; m_off = 1'b0; end
      else if (m_bcnt == B - 1) begin m_bcnt = 0; m_off = !m_off; end
      else m_bcnt++;
    end
    #1;
    e = exp_q.pop_front();
    check_eq({tag, ".anode"}, {8'd0, anode}, {8'd0, e[11:8]});
    check_eq({tag, ".seg"},   {5'd0, seg},   {5'd0, e[7:1]});
    check_eq({tag, ".dp"},    {11'd0, dp},   {11'd0, e[0]});
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    for (int k = 10; k < 16; k++) seg_tab[k] = 7'b0111111;

    reset = 1'b1; blank_lz = 1'b0; blink_en = 1'b0;
    minute_tens = 4'd1; minute_ones = 4'd2; second_tens = 4'd3; second_ones = 4'd4;
    run("reset", 2);
    check_eq("reset_anode_const", {8'd0, anode}, 12'h00F);

    // basic scan 1,2,3,4
    reset = 1'b0;
    run("scan", 40);

    // leading-zero blanking on and off
    minute_tens = 4'd0; blank_lz = 1'b1;
    run("blank_on", 20);
    blank_lz = 1'b0;
    run("blank_off", 20);

    // out-of-range digit shows a dash
    second_ones = 4'hB;
    run("dash", 16);
    second_ones = 4'd4; minute_tens = 4'd1;

    // blink, then drop blink_en in the OFF phase
    blink_en = 1'b1;
    run("blink", 50);
    for (int g = 0; g < 40 && !m_off; g++) tick("blink_wait");
    blink_en = 1'b0;
    run("blink_drop", 10);

    // reset mid-slot at index 2
    for (int g = 0; g < 40 && !(m_idx == 2 && m_cnt == 1); g++) tick("idx2_wait");
    reset = 1'b1;
    run("mid_reset", 1);
    reset = 1'b0;
    run("post_reset", 20);

    // mid-digit input change on index 0
    second_ones = 4'd5;
    for (int g = 0; g < 40 && !(m_idx == 0 && m_cnt == 1); g++) tick("idx0_wait");
    run("so5", 1);
    second_ones = 4'd6;
    run("so6", 6);

    // random inputs including blanking and blinking
    for (int i = 0; i < 200; i++) begin
      second_ones = 4'($urandom_range(0, 15));
      second_tens = 4'($urandom_range(0, 15));
      minute_ones = 4'($urandom_range(0, 15));
      minute_tens = 4'($urandom_range(0, 2));
      blank_lz    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) blink_en = ~blink_en;
      reset = ($urandom_range(0, 63) == 0);
      tick("rand");
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
